// File: rtl/memory_access_unit_pkg.sv
// Shared types and constants for the PSRV32 memory stage.
package mem_access_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int unsigned MAX_WAIT_DEF = 255;
    localparam int unsigned CNT_W        = 8;
    localparam int unsigned XLEN         = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    typedef struct packed {
        logic              we;
        logic [XLEN-1:0]   addr;
        logic [3:0]        be;
        logic [XLEN-1:0]   wdata;
    } dmem_req_t;

    // Legal funct3 for the direction and naturally aligned for its size.
    function automatic logic access_ok(input logic is_load, input logic [2:0] f3,
                                       input logic [1:0] off);
        logic legal;
        logic aligned;
        if (is_load) legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                             (f3 == F3_BU) || (f3 == F3_HU);
        else         legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        case (f3[1:0])
            2'b01:   aligned = ~off[0];
            2'b10:   aligned = (off == 2'b00);
            default: aligned = 1'b1;
        endcase
        return legal & aligned;
    endfunction

endpackage

// File: rtl/memory_access_unit_if.sv
// Data-memory request/grant/response bus.
interface memory_access_unit_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (output req, we, addr, be, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, we, addr, be, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/memory_access_unit_load_align.sv
// Extracts and sign/zero-extends load data; shared with the writeback forwarding path.
module load_align
    import mem_access_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  off_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_c
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = 8'(rdata_i >> {off_i, 3'b000});
        half_v = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        case (funct3_i)
            F3_B:    data_c = {{24{byte_v[7]}}, byte_v};
            F3_BU:   data_c = {24'b0, byte_v};
            F3_H:    data_c = {{16{half_v[15]}}, half_v};
            F3_HU:   data_c = {16'b0, half_v};
            default: data_c = rdata_i;
        endcase
    end

endmodule

// File: rtl/memory_access_unit.sv
// PSRV32 memory stage: runs one data-memory bus transaction per load/store and
// returns aligned load data, stalling upstream while the access is in flight.
module memory_access_unit
    import mem_access_pkg::*;
#(
    parameter int unsigned MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic [31:0]          alu_result_i,
    input  logic [31:0]          store_data_i,
    input  logic                 mem_read_i,
    input  logic                 mem_write_i,
    input  logic [2:0]           funct3_i,
    output logic                 stall_o,
    output logic [31:0]          data_read_o,
    output logic                 valid_o,
    output logic                 misalign_o,
    output logic                 bus_err_o,
    memory_access_unit_if.master dmem
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

    state_t           state_q, state_d;
    dmem_req_t        pl_q, pl_d;
    logic             req_q, req_d;
    logic [2:0]       fmt_q, fmt_d;
    logic [1:0]       off_q, off_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      data_q, data_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;

    logic [31:0]      aligned_c;
    logic [3:0]       be_c;
    logic [31:0]      wdata_c;
    logic             ok_c;
    logic             timeout_c;
    logic             stall_c;
    logic             misalign_c;

    load_align u_align (
        .rdata_i  (dmem.rdata),
        .off_i    (off_q),
        .funct3_i (fmt_q),
        .data_c   (aligned_c)
    );

    // Byte lanes and replicated store data for the incoming access.
    always_comb begin
        case (funct3_i[1:0])
            2'b00: begin
                be_c    = 4'b0001 << alu_result_i[1:0];
                wdata_c = {4{store_data_i[7:0]}};
            end
            2'b01: begin
                be_c    = 4'b0011 << {alu_result_i[1], 1'b0};
                wdata_c = {2{store_data_i[15:0]}};
            end
            default: begin
                be_c    = 4'b1111;
                wdata_c = store_data_i;
            end
        endcase
    end

    assign ok_c      = access_ok(mem_read_i, funct3_i, alu_result_i[1:0]);
    assign timeout_c = (cnt_q == CNT_MAX);

    always_comb begin
        state_d    = state_q;
        pl_d       = pl_q;
        req_d      = req_q;
        fmt_d      = fmt_q;
        off_d      = off_q;
        cnt_d      = cnt_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        err_d      = 1'b0;
        stall_c    = 1'b0;
        misalign_c = 1'b0;

        case (state_q)
            IDLE: begin
                if (mem_read_i || mem_write_i) begin
                    if (ok_c) begin
                        stall_c = 1'b1;
                        pl_d    = '{we:    ~mem_read_i,
                                    addr:  {alu_result_i[31:2], 2'b00},
                                    be:    be_c,
                                    wdata: wdata_c};
                        fmt_d   = funct3_i;
                        off_d   = alu_result_i[1:0];
                        cnt_d   = '0;
                        req_d   = 1'b1;
                        state_d = REQ;
                    end else begin
                        misalign_c = 1'b1;
                    end
                end
            end
            REQ, WAIT: begin
                stall_c = 1'b1;
                cnt_d   = cnt_q + CNT_W'(1);
                if (timeout_c) begin
                    req_d   = 1'b0;
                    data_d  = '0;
                    err_d   = 1'b1;
                    valid_d = 1'b1;
                    state_d = RESP;
                end else if (state_q == REQ) begin
                    // rvalid in REQ is ignored even if it coincides with gnt.
                    if (dmem.gnt) begin
                        req_d   = 1'b0;
                        valid_d = pl_q.we;
                        state_d = pl_q.we ? RESP : WAIT;
                    end
                end else if (dmem.rvalid) begin
                    data_d  = aligned_c;
                    valid_d = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q <= IDLE;
            pl_q    <= '0;
            req_q   <= 1'b0;
            fmt_q   <= '0;
            off_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pl_q    <= pl_d;
            req_q   <= req_d;
            fmt_q   <= fmt_d;
            off_q   <= off_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign stall_o     = stall_c;
    assign misalign_o  = misalign_c;
    assign data_read_o = data_q;
    assign valid_o     = valid_q;
    assign bus_err_o   = err_q;

    assign dmem.req    = req_q;
    assign dmem.we     = pl_q.we;
    assign dmem.addr   = pl_q.addr;
    assign dmem.be     = pl_q.be;
    assign dmem.wdata  = pl_q.wdata;

endmodule

// File: doc/memory_access_unit.md
# memory_access_unit

Memory stage of the PSRV32 pipeline: takes the effective address, store data and memory control signals coming out of execute, runs a request/grant/response transaction on the data-memory bus, and hands aligned, sign/zero-extended load data to the memory/writeback pipeline register. It sizes byte strobes for stores and flags misaligned or illegal accesses. It also stalls upstream stages while a bus transaction is in flight.

## Interface
Parameters:
- MAX_WAIT, 255: bus cycles allowed in REQ+WAIT before a timeout error (8-bit counter).

Ports:
- clk_i  in  1  clock, rising edge.
- reset_i  in  1  reset; asynchronous, active-low.
- alu_result_i  in  32  effective byte address.
- store_data_i  in  32  rs2 value for stores.
- mem_read_i  in  1  load in memory stage.
- mem_write_i  in  1  store in memory stage.
- funct3_i  in  3  access size/sign (RV32I load/store encoding).
- stall_o  out  1  hold all upstream pipeline registers.
- data_read_o  out  32  aligned load data to MEM/WB register (registered).
- valid_o  out  1  access completed this cycle (registered).
- misalign_o  out  1  misaligned or illegal funct3 access (combinational, IDLE only).
- bus_err_o  out  1  timeout pulse (registered).
- dmem_req_o  out  1  bus request.
- dmem_we_o  out  1  1 = write.
- dmem_addr_o  out  32  word address, bits [1:0] = 0.
- dmem_be_o  out  4  byte enables.
- dmem_wdata_o  out  32  lane-replicated store data.
- dmem_gnt_i  in  1  request accepted.
- dmem_rvalid_i  in  1  read data valid.
- dmem_rdata_i  in  32  read data.

## Operation
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE: if mem_read_i or mem_write_i is set, the access is aligned, and funct3_i is legal, do the following. Latch the address word, be, wdata and load format. stall_o=1 combinationally. Next state is REQ.
- If both mem_read_i and mem_write_i are set, the access is treated as a load.
- Misaligned or illegal access in IDLE: misalign_o=1 in the same cycle. No bus request, stall_o=0, state stays IDLE, data_read_o unchanged.
- Misaligned: halfword with addr[0]=1; word with addr[1:0]!=0.
- Illegal funct3: loads 011/110/111; stores other than 000/001/010.
- REQ: dmem_req_o=1. addr, we, be and wdata stay stable until dmem_gnt_i.
  - On gnt, a write goes to RESP.
  - On gnt, a read goes to WAIT.
- WAIT: on dmem_rvalid_i, register the aligned data into data_read_o, then go to RESP.
- RESP: stall_o=0, valid_o=1. Next state is IDLE. Upstream advances at this edge, so the same instruction is never re-issued.
- Load format:
  - LB(000)/LBU(100): byte at addr[1:0], sign- or zero-extended.
  - LH(001)/LHU(101): halfword at addr[1], sign- or zero-extended.
  - LW(010): full word.
- Store format:
  - SB: be=0001<<addr[1:0]; wdata = byte replicated ×4.
  - SH: be=0011<<(2·addr[1]); wdata = halfword replicated ×2.
  - SW: be=1111.
- Timeout: the counter clears on IDLE→REQ and increments each REQ/WAIT cycle. When it reaches MAX_WAIT:
  - bus_err_o pulses for 1 cycle (coincident with RESP);
  - data_read_o is set to 0;
  - state goes to RESP;
  - dmem_req_o drops.
- dmem_rvalid_i and dmem_gnt_i are ignored in IDLE and RESP.

## Timing
- Reset values (async, reset_i=0): state IDLE; dmem_req_o, dmem_we_o, valid_o, bus_err_o, stall_o = 0; dmem_addr_o, dmem_be_o, dmem_wdata_o, data_read_o = 0; counter = 0.
- Best-case load: cycle0 IDLE accept; cycle1 REQ+gnt; cycle2 WAIT+rvalid; cycle3 RESP (valid_o=1, data stable). stall_o is high in cycles 0–2.
- Best-case store: 3 cycles (IDLE, REQ+gnt, RESP).
- stall_o = (IDLE & legal access) | REQ | WAIT.
- Reset mid-transaction aborts immediately. A later rvalid for the aborted request is ignored.
- gnt and rvalid arriving in the same cycle while in REQ: take gnt only and move to WAIT. rvalid is consumed in WAIT only.

## Structure
- Package mem_access_pkg holds:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - state enum;
  - MAX_WAIT default.
- Sub-module load_align: combinational (rdata, addr[1:0], funct3) → 32-bit extended data. It is reused by the writeback forwarding path.

## Test plan
- LB at 0x1003, rdata=0x80FF_1234, gnt and rvalid immediate → data_read_o=0xFFFF_FF80, valid_o=1 in cycle 3, stall_o high for cycles 0–2.
- LHU at 0x2002, rdata=0xBEEF_0000 → 0x0000_BEEF. LW at 0x0 with gnt delayed 3 cycles → addr/be held stable, valid_o at cycle 6.
- SB at 0x0101, data 0x1234_56AB → dmem_addr_o=0x100, be=0010, wdata=0xABAB_ABAB, we=1; SH at 0x0102 → be=1100.
- LW at 0x0002 → misalign_o=1 same cycle, no dmem_req_o, stall_o=0.
- Load with no rvalid for MAX_WAIT cycles → bus_err_o one-cycle pulse, data_read_o=0, FSM back to IDLE.
- reset_i low during WAIT, then rvalid after release → all outputs 0, no valid_o, response ignored.
